// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - shared SM4 constants: word width, owner IDs, S-box table
package sm4_pkg;

  localparam int SM4_WORD_W = 32;

  localparam logic OWNER_KE = 1'b0;
  localparam logic OWNER_RF = 1'b1;

  // SM4 S-box, indexed by the input byte
  localparam logic [7:0] SM4_SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

endpackage

// File: rtl/sm4_sbox.sv
// rtl/sm4_sbox.sv - single-byte SM4 S-box lookup
module sm4_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  import sm4_pkg::*;

  assign dout = SM4_SBOX[din];

endmodule

// File: rtl/sm4_tau.sv
// rtl/sm4_tau.sv - SM4 non-linear transform tau: four parallel byte S-boxes
module sm4_tau (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  import sm4_pkg::*;

  for (genvar i = 0; i < SM4_WORD_W / 8; i++) begin : g_byte
    sm4_sbox u_sbox (
      .din  (din[8*i +: 8]),
      .dout (dout[8*i +: 8])
    );
  end

endmodule

// File: rtl/sm4_sbox_arbiter.sv
// rtl/sm4_sbox_arbiter.sv - round-robin sharing of one tau between key expansion and round function
module sm4_sbox_arbiter #(
  parameter int DATA_W    = 32,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ke_req_valid,
  output logic              ke_req_ready,
  input  logic [DATA_W-1:0] ke_req_data,
  output logic              ke_rsp_valid,
  input  logic              ke_rsp_ready,
  output logic [DATA_W-1:0] ke_rsp_data,
  input  logic              rf_req_valid,
  output logic              rf_req_ready,
  input  logic [DATA_W-1:0] rf_req_data,
  output logic              rf_rsp_valid,
  input  logic              rf_rsp_ready,
  output logic [DATA_W-1:0] rf_rsp_data,
  output logic              busy
);
  import sm4_pkg::*;

  logic              out_valid;
  logic              out_owner;
  logic [DATA_W-1:0] out_data;
  logic              rr_ptr;

  logic              owner_ready;
  logic              stage_free;
  logic              drain;
  logic              grant_ke;
  logic              grant_rf;
  logic              ke_fire;
  logic              rf_fire;
  logic [DATA_W-1:0] tau_in;
  logic [DATA_W-1:0] tau_out;

  // Stage frees up when empty or when its owner takes the result this cycle
  always_comb begin
    owner_ready = (out_owner == OWNER_RF) ? rf_rsp_ready : ke_rsp_ready;
    stage_free  = !out_valid || owner_ready;
    drain       = out_valid && owner_ready;
    grant_ke    = !rf_req_valid || (rr_ptr == OWNER_KE);
    grant_rf    = !ke_req_valid || (rr_ptr == OWNER_RF);
    ke_req_ready = stage_free && grant_ke;
    rf_req_ready = stage_free && grant_rf;
    ke_fire     = ke_req_valid && ke_req_ready;
    rf_fire     = rf_req_valid && rf_req_ready;
    tau_in      = rf_fire ? rf_req_data : ke_req_data;
  end

  sm4_tau u_tau (
    .din  (tau_in),
    .dout (tau_out)
  );

  // Capture the substituted word on a grant, clear on drain, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_owner <= OWNER_KE;
      out_data  <= '0;
      rr_ptr    <= PRIO_INIT;
    end else if (ke_fire || rf_fire) begin
      out_valid <= 1'b1;
      out_owner <= rf_fire ? OWNER_RF : OWNER_KE;
      out_data  <= tau_out;
      rr_ptr    <= rf_fire ? OWNER_KE : OWNER_RF;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // Route the registered result to its owner only
  always_comb begin
    ke_rsp_valid = out_valid && (out_owner == OWNER_KE);
    rf_rsp_valid = out_valid && (out_owner == OWNER_RF);
    ke_rsp_data  = out_data;
    rf_rsp_data  = out_data;
    busy         = out_valid;
  end

endmodule
